// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encodings and port identifiers.
package dmem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } arb_state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-request round-robin picker: with both requests pending, the port that was not served last wins.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_id_o,
  output logic       any_o
);

  always_comb begin
    any_o = |req_i;
    if (&req_i) begin
      grant_id_o = ~last_i;
    end else if (req_i[1]) begin
      grant_id_o = PORT_DBG;
    end else begin
      grant_id_o = PORT_CORE;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the core (port 0) and debug loader (port 1),
// sequencing every access through SETUP, ACCESS, CAPTURE and DONE with fully registered outputs.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_line,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);

  arb_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              win_q, win_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] line_q, line_d;
  logic [DATA_W-1:0] memIn_q, memIn_d;
  logic              rd_q, rd_d, wr_q, wr_d;
  logic              gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic              done0_q, done0_d, done1_q, done1_d;
  logic              busy_q, busy_d;
  logic              grantId;
  logic              anyReq;

  rr_arb2 u_rr (
    .req_i      ({p1_req, p0_req}),
    .last_i     (last_q),
    .grant_id_o (grantId),
    .any_o      (anyReq)
  );

  // Outputs are derived from the next state so they line up with the state they describe.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    win_d   = win_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (anyReq) begin
          state_d = ST_SETUP;
          win_d   = grantId;
          if (grantId == PORT_DBG) begin
            we_d    = p1_we;
            addr_d  = p1_addr;
            wdata_d = p1_wdata;
          end else begin
            we_d    = p0_we;
            addr_d  = p0_addr;
            wdata_d = p0_wdata;
          end
        end
      end
      ST_SETUP:   state_d = ST_ACCESS;
      ST_ACCESS:  state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        state_d = ST_DONE;
        if (!we_q) rdata_d = mem_out;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        last_d  = win_q;
      end
      default:    state_d = ST_IDLE;
    endcase

    rd_d    = (state_d == ST_ACCESS) && !we_d;
    wr_d    = (state_d == ST_ACCESS) && we_d;
    line_d  = (state_d == ST_SETUP) ? addr_d : line_q;
    memIn_d = ((state_d == ST_SETUP) && we_d) ? wdata_d : memIn_q;
    busy_d  = (state_d != ST_IDLE);
    gnt0_d  = busy_d && (win_d == PORT_CORE);
    gnt1_d  = busy_d && (win_d == PORT_DBG);
    done0_d = (state_d == ST_DONE) && (win_d == PORT_CORE);
    done1_d = (state_d == ST_DONE) && (win_d == PORT_DBG);
  end

  // Reset parks the pointer on port 1 so the core wins the first contention.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      win_q   <= PORT_CORE;
      last_q  <= PORT_DBG;
      rdata_q <= '0;
      line_q  <= '0;
      memIn_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      win_q   <= win_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      line_q  <= line_d;
      memIn_q <= memIn_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
    end
  end

  assign p0_gnt    = gnt0_q;
  assign p1_gnt    = gnt1_q;
  assign p0_done   = done0_q;
  assign p1_done   = done1_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_read  = rd_q;
  assign mem_write = wr_q;
  assign mem_line  = line_q;
  assign mem_in    = memIn_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table for single and contended transactions, plus
// hand sequences for held requests, mid-transaction drop and reset during an access.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [6:0] p0_addr = '0, p1_addr = '0;
  logic [7:0] p0_wdata = '0, p1_wdata = '0;
  logic       p0_gnt, p0_done, p1_gnt, p1_done, busy, mem_read, mem_write;
  logic [7:0] rdata, mem_in;
  logic [6:0] mem_line;
  logic [7:0] memOut = '0;
  logic [7:0] memModel [0:127] = '{16: 8'h5A, default: 8'h00};

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rstBefore;
    logic       p0r, p0w;
    logic [6:0] p0a;
    logic [7:0] p0d;
    logic       p1r, p1w;
    logic [6:0] p1a;
    logic [7:0] p1d;
    logic [6:0] expFlags;
    logic [6:0] expLine;
    logic [7:0] expIn;
    logic [7:0] expRdata;
  } vec_t;

  vec_t vecs[$];

  dmem_arbiter dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_done(p0_done),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_done(p1_done),
    .rdata(rdata), .busy(busy), .mem_read(mem_read), .mem_write(mem_write),
    .mem_line(mem_line), .mem_in(mem_in), .mem_out(memOut)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: write and registered read on the strobe edge.
  always @(posedge clk) begin
    if (mem_write) memModel[mem_line] <= mem_in;
    if (mem_read) memOut <= memModel[mem_line];
  end

  task automatic checkOutput(input string nm, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, actual, expected);
    end
  endtask

  function automatic logic [6:0] flags();
    return {p0_gnt, p1_gnt, p0_done, p1_done, busy, mem_read, mem_write};
  endfunction

  function automatic vec_t mk(input logic rb, input logic p0r, input logic p0w, input logic [6:0] p0a,
                              input logic [7:0] p0d, input logic p1r, input logic p1w,
                              input logic [6:0] p1a, input logic [7:0] p1d, input logic [6:0] fl,
                              input logic [6:0] ln, input logic [7:0] mi, input logic [7:0] rd);
    vec_t v;
    v.rstBefore = rb; v.p0r = p0r; v.p0w = p0w; v.p0a = p0a; v.p0d = p0d;
    v.p1r = p1r; v.p1w = p1w; v.p1a = p1a; v.p1d = p1d;
    v.expFlags = fl; v.expLine = ln; v.expIn = mi; v.expRdata = rd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    p0_req = v.p0r; p0_we = v.p0w; p0_addr = v.p0a; p0_wdata = v.p0d;
    p1_req = v.p1r; p1_we = v.p1w; p1_addr = v.p1a; p1_wdata = v.p1d;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      checkOutput("inv_both_gnt", {31'd0, p0_gnt && p1_gnt}, 0);
      checkOutput("inv_rd_wr", {31'd0, mem_read && mem_write}, 0);
      checkOutput("inv_strobe_state", {31'd0, (mem_read || mem_write) && (dut.state_q != ST_ACCESS)}, 0);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [15:0] doneMask;
    logic [7:0]  gntMask, done8;
    int          wrCount;
    logic        seen;

    // Flags: {p0_gnt, p1_gnt, p0_done, p1_done, busy, mem_read, mem_write}
    vecs.push_back(mk(0, 1,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 7'b1000100, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 7'b1000101, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 7'b1000100, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 7'b1010100, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 0,1,7'h05,8'hA5, 0,0,7'h00,8'h00, 7'b0000000, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 7'b1000100, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 7'b1000110, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 7'b1000100, 7'h05, 8'hA5, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h05,8'h00, 0,0,7'h00,8'h00, 7'b1010100, 7'h05, 8'hA5, 8'hA5));
    vecs.push_back(mk(0, 0,0,7'h05,8'h00, 0,0,7'h00,8'h00, 7'b0000000, 7'h05, 8'hA5, 8'hA5));
    vecs.push_back(mk(1, 1,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b1000100, 7'h10, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b1000110, 7'h10, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b1000100, 7'h10, 8'h00, 8'h00));
    vecs.push_back(mk(0, 1,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b1010100, 7'h10, 8'h00, 8'h5A));
    vecs.push_back(mk(0, 0,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b0000000, 7'h10, 8'h00, 8'h5A));
    vecs.push_back(mk(0, 0,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b0100100, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 0,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b0100101, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 0,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b0100100, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 0,0,7'h10,8'h00, 1,1,7'h7F,8'h3C, 7'b0101100, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 0,0,7'h10,8'h00, 0,1,7'h7F,8'h3C, 7'b0000000, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 1,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b1000100, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 1,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b1000110, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 1,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b1000100, 7'h7F, 8'h3C, 8'h5A));
    vecs.push_back(mk(0, 1,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b1010100, 7'h7F, 8'h3C, 8'h3C));
    vecs.push_back(mk(0, 0,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b0000000, 7'h7F, 8'h3C, 8'h3C));
    vecs.push_back(mk(0, 0,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b0100100, 7'h10, 8'hC3, 8'h3C));
    vecs.push_back(mk(0, 0,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b0100101, 7'h10, 8'hC3, 8'h3C));
    vecs.push_back(mk(0, 0,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b0100100, 7'h10, 8'hC3, 8'h3C));
    vecs.push_back(mk(0, 0,0,7'h7F,8'h00, 1,1,7'h10,8'hC3, 7'b0101100, 7'h10, 8'hC3, 8'h3C));
    vecs.push_back(mk(0, 0,0,7'h7F,8'h00, 0,1,7'h10,8'hC3, 7'b0000000, 7'h10, 8'hC3, 8'h3C));

    #12;
    checkOutput("reset_flags", {25'd0, flags()}, 0);
    checkOutput("reset_line", {25'd0, mem_line}, 0);
    checkOutput("reset_in", {24'd0, mem_in}, 0);
    checkOutput("reset_rdata", {24'd0, rdata}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      if (vecs[i].rstBefore) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
      applyStimulus(vecs[i]);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_flags", i), {25'd0, flags()}, {25'd0, vecs[i].expFlags});
      checkOutput($sformatf("v%0d_line", i), {25'd0, mem_line}, {25'd0, vecs[i].expLine});
      checkOutput($sformatf("v%0d_mem_in", i), {24'd0, mem_in}, {24'd0, vecs[i].expIn});
      checkOutput($sformatf("v%0d_rdata", i), {24'd0, rdata}, {24'd0, vecs[i].expRdata});
    end

    // Port 1 holds its request across three back-to-back writes.
    p1_req = 1; p1_we = 1; p1_addr = 7'h30; p1_wdata = 8'h11;
    doneMask = '0; wrCount = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      doneMask[i] = p1_done;
      if (mem_write) wrCount++;
      if (i == 13) p1_req = 0;
    end
    checkOutput("hold_done_cycles", {16'd0, doneMask}, 32'h2108);
    checkOutput("hold_write_count", wrCount, 3);
    checkOutput("hold_mem_30", {24'd0, memModel[7'h30]}, 32'h11);

    // Port 0 drops its request during ACCESS; the write still completes.
    p0_req = 1; p0_we = 1; p0_addr = 7'h20; p0_wdata = 8'h77;
    gntMask = '0; done8 = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      gntMask[i] = p0_gnt;
      done8[i] = p0_done;
      if (i == 1) p0_req = 0;
    end
    checkOutput("drop_gnt_cycles", {24'd0, gntMask}, 32'h0F);
    checkOutput("drop_done_cycles", {24'd0, done8}, 32'h08);
    checkOutput("drop_mem_20", {24'd0, memModel[7'h20]}, 32'h77);

    // Reset asserted during the ACCESS cycle of a read.
    p0_req = 1; p0_we = 0; p0_addr = 7'h05;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_pre_read", {31'd0, mem_read}, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async_flags", {25'd0, flags()}, 0);
    p0_req = 0;
    #3 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      seen = seen | p0_done | p1_done | busy;
    end
    checkOutput("rst_no_done", {31'd0, seen}, 0);

    p0_req = 1; p0_we = 0; p0_addr = 7'h05;
    p1_req = 1; p1_we = 0; p1_addr = 7'h20;
    @(posedge clk); #1;
    checkOutput("rst_first_gnt", {30'd0, p0_gnt, p1_gnt}, 32'h2);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rst_p0_done", {31'd0, p0_done}, 1);
    checkOutput("rst_p0_rdata", {24'd0, rdata}, 32'hA5);
    p0_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("rst_second_gnt", {30'd0, p0_gnt, p1_gnt}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("rst_p1_done", {31'd0, p1_done}, 1);
    checkOutput("rst_p1_rdata", {24'd0, rdata}, 32'h77);
    p1_req = 0;
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
